// File: rtl/axis_video_gen.sv
// AXI4-Stream test-pattern source: frames of width x height beats with line/frame gaps.
// Every AXIS output is a flop; a stalled beat stays put until it is accepted.
module axis_video_gen #(
    parameter int N  = 8,
    parameter int CH = 2,
    parameter int CW = 12
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              en,
    input  logic [CW-1:0]     cfg_width,
    input  logic [CW-1:0]     cfg_height,
    input  logic [CW-1:0]     cfg_hgap,
    input  logic [CW-1:0]     cfg_vgap,
    input  logic [7:0]        cfg_frames,
    input  logic [1:0]        cfg_mode,
    input  logic [N-1:0]      cfg_const,
    input  logic              inj_drop_tuser,
    input  logic              inj_drop_tlast,
    input  logic              inj_short_line,
    output logic [CH*N-1:0]   m_axis_tdata,
    output logic              m_axis_tvalid,
    output logic              m_axis_tlast,
    output logic              m_axis_tuser,
    input  logic              m_axis_tready,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frames_sent
);

    typedef enum logic [2:0] {IDLE, ACTIVE, HGAP, VGAP, DONE} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   x_q, x_d, y_q, y_d, cnt_q, cnt_d;
    logic [CW-1:0]   width_q, width_d, height_q, height_d, hgap_q, hgap_d, vgap_q, vgap_d;
    logic [1:0]      mode_q, mode_d;
    logic [N-1:0]    const_q, const_d;
    logic [7:0]      frames_q, frames_d, sent_q, sent_d, sent_inc;
    logic            done_q, done_d;
    logic [CH*N-1:0] tdata_q, tdata_d;
    logic            tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
    logic            eol_q, eol_d, short_q, short_d;
    logic            inj_tuser_q, inj_tuser_d, inj_tlast_q, inj_tlast_d, inj_short_q, inj_short_d;
    logic            hs, launch, load, frame_end, eol, sof;
    logic [CW-1:0]   ld_x, ld_y;

    function automatic logic [CH*N-1:0] pattern(input logic [1:0] mode, input logic [N-1:0] k,
                                                input logic [CW-1:0] px, input logic [CW-1:0] py);
        logic [CH*N-1:0] d;
        d = '0;
        for (int c = 0; c < CH; c++) begin
            case (mode)
                2'd0:    d[c*N +: N] = N'(px) + N'(c);
                2'd1:    d[c*N +: N] = N'(py) + N'(c);
                2'd2:    d[c*N +: N] = k;
                default: d[c*N +: N] = {N{px[3] ^ py[3]}};
            endcase
        end
        return d;
    endfunction

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        cnt_d       = cnt_q;
        width_d     = width_q;
        height_d    = height_q;
        hgap_d      = hgap_q;
        vgap_d      = vgap_q;
        mode_d      = mode_q;
        const_d     = const_q;
        frames_d    = frames_q;
        sent_d      = sent_q;
        done_d      = 1'b0;
        tdata_d     = tdata_q;
        tvalid_d    = tvalid_q;
        tlast_d     = tlast_q;
        tuser_d     = tuser_q;
        eol_d       = eol_q;
        short_d     = short_q;
        inj_tuser_d = inj_tuser_q | inj_drop_tuser;
        inj_tlast_d = inj_tlast_q | inj_drop_tlast;
        inj_short_d = inj_short_q | inj_short_line;
        hs          = tvalid_q & m_axis_tready;
        sent_inc    = (sent_q == 8'hFF) ? sent_q : sent_q + 8'd1;
        launch      = 1'b0;
        load        = 1'b0;
        frame_end   = 1'b0;
        eol         = 1'b0;
        sof         = 1'b0;
        ld_x        = '0;
        ld_y        = '0;

        case (state_q)
            IDLE: begin
                if (en) begin
                    launch = 1'b1;
                    sent_d = '0;
                end
            end
            ACTIVE: begin
                if (hs) begin
                    if (!eol_q) begin
                        load = 1'b1;
                        ld_x = x_q + CW'(1);
                        ld_y = y_q;
                    end else if (y_q != height_q - CW'(1)) begin
                        if (hgap_q == '0) begin
                            load = 1'b1;
                            ld_y = y_q + CW'(1);
                        end else begin
                            state_d  = HGAP;
                            cnt_d    = hgap_q;
                            tvalid_d = 1'b0;
                        end
                    end else begin
                        done_d = 1'b1;
                        sent_d = sent_inc;
                        if (vgap_q == '0) begin
                            frame_end = 1'b1;
                        end else begin
                            state_d  = VGAP;
                            cnt_d    = vgap_q;
                            tvalid_d = 1'b0;
                        end
                    end
                end
            end
            HGAP: begin
                if (cnt_q == CW'(1)) begin
                    state_d = ACTIVE;
                    load    = 1'b1;
                    ld_y    = y_q + CW'(1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            VGAP: begin
                if (cnt_q == CW'(1)) frame_end = 1'b1;
                else                 cnt_d = cnt_q - CW'(1);
            end
            DONE: begin
                if (!en) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Frame boundary: either the run is complete, or a fresh frame picks up new config.
        if (frame_end) begin
            tvalid_d = 1'b0;
            if (frames_q != '0 && sent_d == frames_q) state_d = DONE;
            else if (en)                              launch  = 1'b1;
            else                                      state_d = IDLE;
        end

        if (launch) begin
            state_d  = ACTIVE;
            load     = 1'b1;
            width_d  = (cfg_width == '0) ? CW'(1) : cfg_width;
            height_d = (cfg_height == '0) ? CW'(1) : cfg_height;
            hgap_d   = cfg_hgap;
            vgap_d   = cfg_vgap;
            mode_d   = cfg_mode;
            const_d  = cfg_const;
            frames_d = cfg_frames;
        end

        // Load the next beat into the output register; injection flags are consumed here.
        if (load) begin
            sof = (ld_x == '0) && (ld_y == '0);
            if (ld_x == '0) begin
                short_d     = inj_short_d && (width_d > CW'(1));
                inj_short_d = 1'b0;
            end
            eol      = (ld_x == width_d - CW'(1)) || (short_d && ld_x == width_d - CW'(2));
            tdata_d  = pattern(mode_d, const_d, ld_x, ld_y);
            tuser_d  = sof & ~inj_tuser_d;
            tlast_d  = eol & ~inj_tlast_d;
            if (sof) inj_tuser_d = 1'b0;
            if (eol) inj_tlast_d = 1'b0;
            eol_d    = eol;
            tvalid_d = 1'b1;
            x_d      = ld_x;
            y_d      = ld_y;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            x_q         <= '0;
            y_q         <= '0;
            cnt_q       <= '0;
            width_q     <= '0;
            height_q    <= '0;
            hgap_q      <= '0;
            vgap_q      <= '0;
            mode_q      <= '0;
            const_q     <= '0;
            frames_q    <= '0;
            sent_q      <= '0;
            done_q      <= 1'b0;
            tdata_q     <= '0;
            tvalid_q    <= 1'b0;
            tlast_q     <= 1'b0;
            tuser_q     <= 1'b0;
            eol_q       <= 1'b0;
            short_q     <= 1'b0;
            inj_tuser_q <= 1'b0;
            inj_tlast_q <= 1'b0;
            inj_short_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cnt_q       <= cnt_d;
            width_q     <= width_d;
            height_q    <= height_d;
            hgap_q      <= hgap_d;
            vgap_q      <= vgap_d;
            mode_q      <= mode_d;
            const_q     <= const_d;
            frames_q    <= frames_d;
            sent_q      <= sent_d;
            done_q      <= done_d;
            tdata_q     <= tdata_d;
            tvalid_q    <= tvalid_d;
            tlast_q     <= tlast_d;
            tuser_q     <= tuser_d;
            eol_q       <= eol_d;
            short_q     <= short_d;
            inj_tuser_q <= inj_tuser_d;
            inj_tlast_q <= inj_tlast_d;
            inj_short_q <= inj_short_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = tuser_q;
    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign frame_done    = done_q;
    assign frames_sent   = sent_q;

endmodule

// File: tb/tb_axis_video_gen.sv
// Bench for axis_video_gen: scenario tasks compare captured beats against a frame model.
module tb_axis_video_gen;
    localparam int N  = 8;
    localparam int CH = 2;
    localparam int CW = 12;

    logic              clk = 1'b0;
    logic              aresetn = 1'b0;
    logic              en = 1'b0;
    logic [CW-1:0]     cfg_width = '0, cfg_height = '0, cfg_hgap = '0, cfg_vgap = '0;
    logic [7:0]        cfg_frames = '0;
    logic [1:0]        cfg_mode = '0;
    logic [N-1:0]      cfg_const = '0;
    logic              inj_drop_tuser = 1'b0, inj_drop_tlast = 1'b0, inj_short_line = 1'b0;
    logic [CH*N-1:0]   m_axis_tdata;
    logic              m_axis_tvalid, m_axis_tlast, m_axis_tuser;
    logic              m_axis_tready = 1'b1;
    logic              busy, frame_done;
    logic [7:0]        frames_sent;

    axis_video_gen #(.N(N), .CH(CH), .CW(CW)) dut (
        .clk(clk), .aresetn(aresetn), .en(en),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_hgap(cfg_hgap), .cfg_vgap(cfg_vgap),
        .cfg_frames(cfg_frames), .cfg_mode(cfg_mode), .cfg_const(cfg_const),
        .inj_drop_tuser(inj_drop_tuser), .inj_drop_tlast(inj_drop_tlast), .inj_short_line(inj_short_line),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
        .busy(busy), .frame_done(frame_done), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fd_cnt = 0, stab_err = 0, drop_err = 0;
    int rdy_mode = 0;
    logic [CH*N-1:0] got_d[$];
    bit              got_u[$];
    bit              got_l[$];
    int              got_c[$];
    logic [CH*N-1:0] exp_d[$];
    bit              exp_u[$];
    bit              exp_l[$];
    bit              prev_stall = 1'b0;
    logic [CH*N+1:0] prev_out = '0;

    // Passive monitor: accepted beats, AXIS stall rules and frame_done pulses.
    always @(negedge clk) begin
        cyc++;
        if (!aresetn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                if (!m_axis_tvalid) drop_err++;
                else if ({m_axis_tdata, m_axis_tuser, m_axis_tlast} !== prev_out) stab_err++;
            end
            if (m_axis_tvalid && m_axis_tready) begin
                got_d.push_back(m_axis_tdata);
                got_u.push_back(m_axis_tuser);
                got_l.push_back(m_axis_tlast);
                got_c.push_back(cyc);
            end
            if (frame_done) fd_cnt++;
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_out   = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
        end
    end

    // Reference frame builder: beats in raster order, straight from the pattern rules.
    task automatic model(input int w, input int h, input int mode, input int k, input int nfr,
                         input bit drop_tl0, input bit short1, input bit drop_tu2);
        int lw;
        logic [CH*N-1:0] d;
        if (w == 0) w = 1;
        if (h == 0) h = 1;
        for (int f = 0; f < nfr; f++) begin
            for (int y = 0; y < h; y++) begin
                lw = (f == 0 && y == 1 && short1 && w >= 2) ? w - 1 : w;
                for (int x = 0; x < lw; x++) begin
                    for (int c = 0; c < CH; c++) begin
                        case (mode)
                            0: d[c*N +: N] = N'((x + c) % (1 << N));
                            1: d[c*N +: N] = N'((y + c) % (1 << N));
                            2: d[c*N +: N] = N'(k);
                            default: d[c*N +: N] = ((((x >> 3) ^ (y >> 3)) & 1) != 0) ? {N{1'b1}} : {N{1'b0}};
                        endcase
                    end
                    exp_d.push_back(d);
                    exp_u.push_back(x == 0 && y == 0 && !(f == 1 && drop_tu2));
                    exp_l.push_back(x == lw - 1 && !(f == 0 && y == 0 && drop_tl0));
                end
            end
        end
    endtask

    task automatic set_cfg(input int w, input int h, input int hg, input int vg,
                           input int fr, input int md, input int k);
        cfg_width  = CW'(w);
        cfg_height = CW'(h);
        cfg_hgap   = CW'(hg);
        cfg_vgap   = CW'(vg);
        cfg_frames = 8'(fr);
        cfg_mode   = 2'(md);
        cfg_const  = N'(k);
    endtask

    task automatic clear_mon();
        got_d.delete(); got_u.delete(); got_l.delete(); got_c.delete();
        exp_d.delete(); exp_u.delete(); exp_l.delete();
        fd_cnt = 0; stab_err = 0; drop_err = 0;
    endtask

    task automatic start(input int rm);
        rdy_mode = rm;
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
        en = 1'b1;
    endtask

    task automatic drive_rdy();
        case (rdy_mode)
            0:       m_axis_tready = 1'b1;
            1:       m_axis_tready = ~m_axis_tready;
            default: m_axis_tready = ($urandom_range(3) != 0);
        endcase
    endtask

    task automatic wait_done(input int budget, output bit to);
        int n = 0;
        bit seen = 0;
        to = 0;
        while (1) begin
            @(posedge clk); #1;
            drive_rdy();
            @(negedge clk);
            if (busy) seen = 1;
            else if (seen) break;
            n++;
            if (n > budget) begin to = 1; break; end
        end
        @(posedge clk); #1;
        m_axis_tready = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({m_axis_tvalid, m_axis_tlast, m_axis_tuser} !== 3'b000) begin
            errors++; $display("FAIL rst_ctl got %b exp 000", {m_axis_tvalid, m_axis_tlast, m_axis_tuser});
        end
        checks++;
        if (m_axis_tdata !== '0) begin errors++; $display("FAIL rst_tdata got %h exp 0", m_axis_tdata); end
        checks++;
        if ({busy, frame_done} !== 2'b00) begin errors++; $display("FAIL rst_busy got %b exp 00", {busy, frame_done}); end
        checks++;
        if (frames_sent !== 8'd0) begin errors++; $display("FAIL rst_frames got %0d exp 0", frames_sent); end
        aresetn = 1'b1;
    endtask

    task automatic test_basic(input int rm, input string nm);
        bit to;
        clear_mon();
        set_cfg(4, 2, 2, 3, 1, 0, 0);
        model(4, 2, 0, 0, 1, 0, 0, 0);
        start(rm);
        if (rm == 0) begin
            @(negedge clk);
            checks++;
            if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL %s_lat0 got %b exp 0", nm, m_axis_tvalid); end
            @(negedge clk);
            checks++;
            if ({m_axis_tvalid, m_axis_tuser} !== 2'b11) begin
                errors++; $display("FAIL %s_lat1 got %b exp 11", nm, {m_axis_tvalid, m_axis_tuser});
            end
        end
        wait_done(500, to);
        checks++;
        if (to) begin errors++; $display("FAIL %s_timeout got timeout exp done", nm); end
        checks++;
        if (got_d.size() != exp_d.size()) begin errors++; $display("FAIL %s_count got %0d exp %0d", nm, got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++;
            if ({got_d[i], got_u[i], got_l[i]} !== {exp_d[i], exp_u[i], exp_l[i]}) begin
                errors++; $display("FAIL %s_beat%0d got %h exp %h", nm, i, {got_d[i], got_u[i], got_l[i]}, {exp_d[i], exp_u[i], exp_l[i]});
            end
        end
        if (rm == 0 && got_c.size() > 4) begin
            checks++;
            if (got_c[4] - got_c[3] != 3) begin errors++; $display("FAIL %s_hgap got %0d exp 3", nm, got_c[4] - got_c[3]); end
        end
        checks++;
        if (stab_err != 0 || drop_err != 0) begin errors++; $display("FAIL %s_stall got %0d/%0d exp 0/0", nm, stab_err, drop_err); end
        repeat (5) @(negedge clk);
        checks++;
        if ({fd_cnt, 8'(frames_sent)} !== {32'd1, 8'd1}) begin errors++; $display("FAIL %s_frames got %0d/%0d exp 1/1", nm, fd_cnt, frames_sent); end
        checks++;
        if ({busy, m_axis_tvalid} !== 2'b00 || got_d.size() != exp_d.size()) begin
            errors++; $display("FAIL %s_done_hold got busy=%b valid=%b beats=%0d exp 0 0 %0d", nm, busy, m_axis_tvalid, got_d.size(), exp_d.size());
        end
        @(posedge clk); #1 en = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_random();
        bit to;
        int w, h, hg, vg, md, k;
        for (int it = 0; it < 5; it++) begin
            clear_mon();
            w = $urandom_range(20, 1); h = $urandom_range(4, 1);
            hg = $urandom_range(3); vg = $urandom_range(3);
            md = $urandom_range(3); k = $urandom_range(255);
            set_cfg(w, h, hg, vg, 1, md, k);
            model(w, h, md, k, 1, 0, 0, 0);
            start(2);
            wait_done(3000, to);
            @(posedge clk); #1 en = 1'b0;
            checks++;
            if (to || got_d.size() != exp_d.size()) begin
                errors++; $display("FAIL rnd%0d_count got %0d exp %0d to=%0d", it, got_d.size(), exp_d.size(), to);
            end
            for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
                checks++;
                if ({got_d[i], got_u[i], got_l[i]} !== {exp_d[i], exp_u[i], exp_l[i]}) begin
                    errors++; $display("FAIL rnd%0d_beat%0d got %h exp %h", it, i, {got_d[i], got_u[i], got_l[i]}, {exp_d[i], exp_u[i], exp_l[i]});
                end
            end
            checks++;
            if (stab_err != 0 || drop_err != 0 || fd_cnt != 1) begin
                errors++; $display("FAIL rnd%0d_proto got %0d/%0d/%0d exp 0/0/1", it, stab_err, drop_err, fd_cnt);
            end
            repeat (2) @(posedge clk);
        end
    endtask

    task automatic test_width1();
        bit to;
        clear_mon();
        set_cfg(1, 3, 0, 0, 1, 1, 0);
        model(1, 3, 1, 0, 1, 0, 0, 0);
        start(0);
        wait_done(200, to);
        @(posedge clk); #1 en = 1'b0;
        checks++;
        if (to || got_d.size() != 3) begin errors++; $display("FAIL w1_count got %0d exp 3", got_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++;
            if ({got_d[i], got_u[i], got_l[i]} !== {exp_d[i], exp_u[i], exp_l[i]}) begin
                errors++; $display("FAIL w1_beat%0d got %h exp %h", i, {got_d[i], got_u[i], got_l[i]}, {exp_d[i], exp_u[i], exp_l[i]});
            end
        end
        for (int i = 1; i < got_c.size(); i++) begin
            checks++;
            if (got_c[i] - got_c[i-1] != 1) begin errors++; $display("FAIL w1_b2b%0d got %0d exp 1", i, got_c[i] - got_c[i-1]); end
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_inject();
        bit to;
        int n = 0;
        clear_mon();
        set_cfg(5, 2, 2, 1, 2, 0, 0);
        model(5, 2, 0, 0, 2, 1, 1, 1);
        start(0);
        while (got_d.size() == 0 && n < 50) begin @(posedge clk); #1; n++; end
        inj_drop_tlast = 1'b1;
        @(posedge clk); #1;
        inj_drop_tlast = 1'b0; inj_short_line = 1'b1; inj_drop_tuser = 1'b1;
        @(posedge clk); #1;
        inj_drop_tuser = 1'b0;
        @(posedge clk); #1;
        inj_short_line = 1'b0;
        wait_done(500, to);
        @(posedge clk); #1 en = 1'b0;
        checks++;
        if (to || got_d.size() != exp_d.size()) begin errors++; $display("FAIL inj_count got %0d exp %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++;
            if ({got_d[i], got_u[i], got_l[i]} !== {exp_d[i], exp_u[i], exp_l[i]}) begin
                errors++; $display("FAIL inj_beat%0d got %h exp %h", i, {got_d[i], got_u[i], got_l[i]}, {exp_d[i], exp_u[i], exp_l[i]});
            end
        end
        checks++;
        if (fd_cnt != 2 || frames_sent !== 8'd2) begin errors++; $display("FAIL inj_frames got %0d/%0d exp 2/2", fd_cnt, frames_sent); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_en_drop();
        int seen = 0, n = 0, busy_cyc = 0, k;
        clear_mon();
        k = $urandom_range(255);
        set_cfg(3, 2, 1, 2, 0, 2, k);
        model(3, 2, 2, k, 2, 0, 0, 0);
        start(0);
        while (seen == 0 && n < 400) begin @(negedge clk); n++; if (frame_done) seen = 1; end
        repeat (4) @(posedge clk);
        #1 en = 1'b0;
        while (seen == 1 && n < 400) begin @(negedge clk); n++; if (frame_done) seen = 2; end
        while (busy && n < 400) begin busy_cyc++; @(negedge clk); n++; end
        repeat (5) @(negedge clk);
        checks++;
        if (seen != 2) begin errors++; $display("FAIL endrop_timeout got %0d frame_done exp 2", seen); end
        checks++;
        if (got_d.size() != 12) begin errors++; $display("FAIL endrop_count got %0d exp 12", got_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++;
            if ({got_d[i], got_u[i], got_l[i]} !== {exp_d[i], exp_u[i], exp_l[i]}) begin
                errors++; $display("FAIL endrop_beat%0d got %h exp %h", i, {got_d[i], got_u[i], got_l[i]}, {exp_d[i], exp_u[i], exp_l[i]});
            end
        end
        checks++;
        if (frames_sent !== 8'd2) begin errors++; $display("FAIL endrop_sent got %0d exp 2", frames_sent); end
        checks++;
        if (busy_cyc != 2) begin errors++; $display("FAIL endrop_vgap got %0d exp 2", busy_cyc); end
        checks++;
        if ({busy, m_axis_tvalid} !== 2'b00) begin errors++; $display("FAIL endrop_idle got %b exp 00", {busy, m_axis_tvalid}); end
    endtask

    task automatic test_reset_mid();
        bit to;
        int n = 0, k = 0;
        clear_mon();
        set_cfg(4, 2, 1, 1, 0, 0, 0);
        start(0);
        while (n < 200) begin
            @(negedge clk); n++;
            if (m_axis_tvalid && k == 6) break;
            if (m_axis_tvalid && m_axis_tready) k++;
        end
        checks++;
        if (k != 6 || m_axis_tdata[N-1:0] !== 8'd2) begin errors++; $display("FAIL midrst_pos got beat %0d x=%0d exp 6 2", k, m_axis_tdata[N-1:0]); end
        aresetn = 1'b0;
        #1;
        checks++;
        if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, busy} !== 4'b0000) begin
            errors++; $display("FAIL midrst_ctl got %b exp 0000", {m_axis_tvalid, m_axis_tuser, m_axis_tlast, busy});
        end
        checks++;
        if (m_axis_tdata !== '0) begin errors++; $display("FAIL midrst_tdata got %h exp 0", m_axis_tdata); end
        @(negedge clk); @(negedge clk);
        aresetn = 1'b1;
        clear_mon();
        @(negedge clk);
        checks++;
        if ({m_axis_tvalid, m_axis_tuser, m_axis_tdata} !== {2'b11, 8'd1, 8'd0}) begin
            errors++; $display("FAIL midrst_first got %h exp %h", {m_axis_tvalid, m_axis_tuser, m_axis_tdata}, {2'b11, 8'd1, 8'd0});
        end
        @(posedge clk); #1 en = 1'b0;
        model(4, 2, 0, 0, 1, 0, 0, 0);
        wait_done(300, to);
        checks++;
        if (to || got_d.size() != exp_d.size()) begin errors++; $display("FAIL midrst_count got %0d exp %0d", got_d.size(), exp_d.size()); end
        for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
            checks++;
            if ({got_d[i], got_u[i], got_l[i]} !== {exp_d[i], exp_u[i], exp_l[i]}) begin
                errors++; $display("FAIL midrst_beat%0d got %h exp %h", i, {got_d[i], got_u[i], got_l[i]}, {exp_d[i], exp_u[i], exp_l[i]});
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish exp finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic(0, "basic");
        test_basic(1, "stall");
        test_width1();
        test_inject();
        test_random();
        test_en_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_video_gen.md
AXIS_VIDEO_GEN -- requirements
Module: axis_video_gen

Interface
REQ-001 SHALL have parameter N, default 8, bits per channel.
REQ-002 SHALL have parameter CH, default 2, channels packed per beat; channel c occupies tdata[c*N +: N].
REQ-003 SHALL have parameter CW, default 12, width of all geometry and gap config fields.
REQ-004 SHALL have port clk  in  1  clock, all logic on rising edge.
REQ-005 SHALL have port aresetn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  in  1  level: start frames and continue generating.
REQ-007 SHALL have ports cfg_width, cfg_height  in  CW each  pixels per line and lines per frame (0 treated as 1).
REQ-008 SHALL have ports cfg_hgap, cfg_vgap  in  CW each  idle cycles after each line and after each frame.
REQ-009 SHALL have port cfg_frames  in  8  frames to send; 0 = unlimited.
REQ-010 SHALL have ports cfg_mode  in  2 and cfg_const  in  N  pattern select and constant value.
REQ-011 SHALL have ports inj_drop_tuser, inj_drop_tlast, inj_short_line  in  1 each  single-cycle error-injection requests.
REQ-012 SHALL have ports m_axis_tdata  out  CH*N, m_axis_tvalid/tlast/tuser  out  1, and m_axis_tready  in  1.
REQ-013 SHALL have ports busy  out  1, frame_done  out  1 (one-cycle pulse), and frames_sent  out  8.

Function
REQ-014 SHALL implement FSM states IDLE, ACTIVE, HGAP, VGAP, DONE.
REQ-015 IDLE→ACTIVE when en=1; cfg_* geometry, gaps, mode and cfg_frames SHALL be latched at this transition and at each VGAP→ACTIVE, never mid-frame.
REQ-016 In ACTIVE, tvalid SHALL be 1; a beat completes only when tvalid&&tready; x advances per completed beat.
REQ-017 While tvalid=1 and tready=0, tdata/tlast/tuser SHALL hold stable (AXI4-Stream rule); tvalid SHALL NOT drop before a handshake.
REQ-018 tuser SHALL be 1 only on beat x=0,y=0; tlast SHALL be 1 only on beat x=width-1.
REQ-019 When width=1, tuser and tlast SHALL both assert on the single first beat.
REQ-020 Pattern, channel c: mode 0 = (x+c) mod 2^N; mode 1 = (y+c) mod 2^N; mode 2 = cfg_const; mode 3 = all-ones if x[3]^y[3] else 0.
REQ-021 After a tlast handshake, when y<height-1: ACTIVE→HGAP for cfg_hgap cycles with tvalid=0, then →ACTIVE with y+1; hgap=0 SHALL give back-to-back lines with no bubble.
REQ-022 After the tlast handshake of line height-1: frame_done pulses one cycle, frames_sent increments (saturating at 255), →VGAP for cfg_vgap cycles.
REQ-023 VGAP end: →DONE if cfg_frames≠0 and frames_sent of this run = cfg_frames; else →ACTIVE if en=1; else →IDLE.
REQ-024 DONE SHALL hold tvalid=0 until en=0, then →IDLE; frames_sent clears on the next IDLE→ACTIVE.
REQ-025 Deasserting en mid-frame SHALL NOT truncate; the current frame completes, then IDLE.
REQ-026 Each inj_* pulse SHALL set a sticky flag consumed by the next applicable beat; repeated pulses before consumption collapse to one.
REQ-027 inj_drop_tuser: next SOF beat has tuser=0, data unchanged.
REQ-028 inj_drop_tlast: next EOL beat has tlast=0, line still counted complete, gap still inserted.
REQ-029 inj_short_line: next line ends with tlast at x=width-2 (width-1 beats); ignored and cleared if width<2.
REQ-030 busy SHALL be 1 in all states except IDLE and DONE.
REQ-031 All AXIS outputs SHALL be registered; first beat is valid one cycle after the IDLE→ACTIVE decision.

Reset
REQ-032 On aresetn=0: state IDLE, tvalid/tlast/tuser=0, tdata=0, busy=0, frame_done=0, frames_sent=0, inj flags cleared, x=y=0.
REQ-033 Reset asserted mid-frame SHALL abort immediately; after release the next frame starts at x=0,y=0 with tuser=1.

Verification
REQ-034 width=4, height=2, hgap=2, vgap=3, mode 0, CH=2, tready=1, cfg_frames=1 -> ch0 tdata 0,1,2,3 per line; tuser on beat 0 only; tlast on beats 3,7; 2 idle cycles between lines; 1 frame_done; DONE.
REQ-035 Same config, tready toggling 1010… -> identical beat sequence; data stable across every stall; no tvalid drop before handshake.
REQ-036 width=1, height=3, hgap=0 -> 3 beats, each tlast=1; first beat also tuser=1.
REQ-037 inj_drop_tlast pulsed during line 0, then inj_short_line -> line 0 has no tlast; line 1 has tlast on beat width-2; following frame normal.
REQ-038 cfg_frames=0, en dropped during frame 2 -> frame 2 completes, vgap elapses, IDLE; frames_sent=2.
REQ-039 aresetn pulsed low at x=2,y=1 -> outputs 0 within the reset; after release, first beat has tuser=1, tdata for x=0.
